// File: rtl/control_signal_unit.sv
// Main control decoder for the 16-bit MIPS-style core: registered datapath
// strobes decoded from the 3-bit opcode, one cycle of latency.
module control_signal_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    output logic       jump,
    output logic       branch,
    output logic       memRead,
    output logic       memtoReg,
    output logic       memWrite,
    output logic       ALUsrc,
    output logic       regWrite,
    output logic       sign_or_zero,
    output logic [1:0] ALUop,
    output logic [1:0] regDst
);

    typedef enum logic [2:0] {
        OP_RTYPE = 3'b000,
        OP_SLTIU = 3'b001,
        OP_J     = 3'b010,
        OP_JAL   = 3'b011,
        OP_LW    = 3'b100,
        OP_SW    = 3'b101,
        OP_BEQ   = 3'b110,
        OP_ADDI  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10
    } regdst_e;

    typedef enum logic [1:0] {
        ALU_RTYPE = 2'b00,
        ALU_BEQ   = 2'b01,
        ALU_SLTIU = 2'b10,
        ALU_ADD   = 2'b11
    } aluop_e;

    logic       jump_d, branch_d, memRead_d, memtoReg_d, memWrite_d;
    logic       ALUsrc_d, regWrite_d, sign_or_zero_d;
    logic [1:0] ALUop_d, regDst_d;

    logic       jump_q, branch_q, memRead_q, memtoReg_q, memWrite_q;
    logic       ALUsrc_q, regWrite_q, sign_or_zero_q;
    logic [1:0] ALUop_q, regDst_q;

    // Defaults are the all-zero NOP; an unknown opcode falls to the default arm.
    always_comb begin
        jump_d         = 1'b0;
        branch_d       = 1'b0;
        memRead_d      = 1'b0;
        memtoReg_d     = 1'b0;
        memWrite_d     = 1'b0;
        ALUsrc_d       = 1'b0;
        regWrite_d     = 1'b0;
        sign_or_zero_d = 1'b0;
        ALUop_d        = '0;
        regDst_d       = '0;
        case (opcode)
            OP_RTYPE: begin
                regDst_d       = DST_RD;
                ALUop_d        = ALU_RTYPE;
                regWrite_d     = 1'b1;
                sign_or_zero_d = 1'b1;
            end
            OP_SLTIU: begin
                regDst_d       = DST_RT;
                ALUop_d        = ALU_SLTIU;
                ALUsrc_d       = 1'b1;
                regWrite_d     = 1'b1;
            end
            OP_J: begin
                jump_d         = 1'b1;
                ALUop_d        = ALU_RTYPE;
                sign_or_zero_d = 1'b1;
            end
            OP_JAL: begin
                jump_d         = 1'b1;
                regDst_d       = DST_RA;
                regWrite_d     = 1'b1;
                sign_or_zero_d = 1'b1;
            end
            OP_LW: begin
                ALUop_d        = ALU_ADD;
                ALUsrc_d       = 1'b1;
                memRead_d      = 1'b1;
                memtoReg_d     = 1'b1;
                regWrite_d     = 1'b1;
                regDst_d       = DST_RT;
                sign_or_zero_d = 1'b1;
            end
            OP_SW: begin
                ALUop_d        = ALU_ADD;
                ALUsrc_d       = 1'b1;
                memWrite_d     = 1'b1;
                sign_or_zero_d = 1'b1;
            end
            OP_BEQ: begin
                branch_d       = 1'b1;
                ALUop_d        = ALU_BEQ;
                sign_or_zero_d = 1'b1;
            end
            OP_ADDI: begin
                ALUop_d        = ALU_ADD;
                ALUsrc_d       = 1'b1;
                regWrite_d     = 1'b1;
                regDst_d       = DST_RT;
                sign_or_zero_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            jump_q         <= 1'b0;
            branch_q       <= 1'b0;
            memRead_q      <= 1'b0;
            memtoReg_q     <= 1'b0;
            memWrite_q     <= 1'b0;
            ALUsrc_q       <= 1'b0;
            regWrite_q     <= 1'b0;
            sign_or_zero_q <= 1'b0;
            ALUop_q        <= '0;
            regDst_q       <= '0;
        end else begin
            jump_q         <= jump_d;
            branch_q       <= branch_d;
            memRead_q      <= memRead_d;
            memtoReg_q     <= memtoReg_d;
            memWrite_q     <= memWrite_d;
            ALUsrc_q       <= ALUsrc_d;
            regWrite_q     <= regWrite_d;
            sign_or_zero_q <= sign_or_zero_d;
            ALUop_q        <= ALUop_d;
            regDst_q       <= regDst_d;
        end
    end

    assign jump         = jump_q;
    assign branch       = branch_q;
    assign memRead      = memRead_q;
    assign memtoReg     = memtoReg_q;
    assign memWrite     = memWrite_q;
    assign ALUsrc       = ALUsrc_q;
    assign regWrite     = regWrite_q;
    assign sign_or_zero = sign_or_zero_q;
    assign ALUop        = ALUop_q;
    assign regDst       = regDst_q;

endmodule

// File: tb/tb_control_signal_unit.sv
// Directed plus random checks of control_signal_unit against a decode table
// taken straight from the instruction list.
module tb_control_signal_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       jump, branch, memRead, memtoReg, memWrite;
    logic       ALUsrc, regWrite, sign_or_zero;
    logic [1:0] ALUop, regDst;

    int checks   = 0;
    int failures = 0;

    // Vector layout: jump branch memRead memtoReg memWrite ALUsrc regWrite sign ALUop[1:0] regDst[1:0]
    logic [11:0] table_q [8];
    logic [11:0] obs, expv;

    control_signal_unit dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .jump         (jump),
        .branch       (branch),
        .memRead      (memRead),
        .memtoReg     (memtoReg),
        .memWrite     (memWrite),
        .ALUsrc       (ALUsrc),
        .regWrite     (regWrite),
        .sign_or_zero (sign_or_zero),
        .ALUop        (ALUop),
        .regDst       (regDst)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {jump, branch, memRead, memtoReg, memWrite, ALUsrc,
                regWrite, sign_or_zero, ALUop, regDst};
    endfunction

    // Drive at negedge, then sample 1 time unit after the following posedge.
    task automatic step(input logic r, input logic [2:0] op);
        @(negedge clk);
        rst    = r;
        opcode = op;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic r, input logic [2:0] op);
        expv = r ? 12'b0 : table_q[op];
        obs  = observed();
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s op=%0d rst=%0b observed=%b expected=%b", tag, op, r, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    initial begin
        logic       r;
        logic [2:0] op;

        table_q[0] = 12'b0000_0011_00_01; // R-type
        table_q[1] = 12'b0000_0110_10_00; // sltiu
        table_q[2] = 12'b1000_0001_00_00; // j
        table_q[3] = 12'b1000_0011_00_10; // jal
        table_q[4] = 12'b0011_0111_11_00; // lw
        table_q[5] = 12'b0000_1101_11_00; // sw
        table_q[6] = 12'b0100_0001_01_00; // beq
        table_q[7] = 12'b0000_0111_11_00; // addi

        rst = 1'b1;
        opcode = 3'b100;

        step(1'b1, 3'b100); check_vec("reset_edge1", 1'b1, 3'b100);
        step(1'b1, 3'b100); check_vec("reset_edge2", 1'b1, 3'b100);
        check_bit("reset_sign_zero", sign_or_zero, 1'b0);

        step(1'b0, 3'b000); check_vec("release_rtype", 1'b0, 3'b000);
        check_bit("release_sign", sign_or_zero, 1'b1);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'(i));
            check_vec("sweep", 1'b0, 3'(i));
            if (i == 4) begin
                check_bit("lw_memRead", memRead, 1'b1);
                check_bit("lw_memtoReg", memtoReg, 1'b1);
                check_bit("lw_ALUop1", ALUop[1], 1'b1);
            end
        end

        step(1'b0, 3'b001); check_vec("seq_sltiu", 1'b0, 3'b001);
        check_bit("sltiu_sign", sign_or_zero, 1'b0);
        step(1'b0, 3'b010); check_vec("seq_j", 1'b0, 3'b010);
        check_bit("j_regWrite", regWrite, 1'b0);
        step(1'b0, 3'b011); check_vec("seq_jal", 1'b0, 3'b011);
        check_bit("jal_regDst1", regDst[1], 1'b1);

        step(1'b0, 3'b101); check_vec("store", 1'b0, 3'b101);
        check_bit("sw_memWrite", memWrite, 1'b1);
        step(1'b0, 3'b110); check_vec("branch", 1'b0, 3'b110);
        check_bit("beq_memWrite", memWrite, 1'b0);

        step(1'b0, 3'b111); check_vec("mid_addi", 1'b0, 3'b111);
        step(1'b1, 3'b111); check_vec("mid_reset", 1'b1, 3'b111);
        step(1'b0, 3'b001); check_vec("mid_release_sltiu", 1'b0, 3'b001);

        for (int n = 0; n < 1000; n++) begin
            r  = ($urandom_range(0, 19) == 0);
            op = 3'($urandom_range(0, 7));
            step(r, op);
            check_vec("random", r, op);
            check_bit("inv_mem_rw", memRead & memWrite, 1'b0);
            check_bit("inv_jump_branch", jump & branch, 1'b0);
            check_bit("inv_memtoReg", memtoReg & ~memRead, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
